// File: rtl/aula_20201105_ledr_fader.sv
`default_nettype none
// ============================================================================
// Module   : aula_20201105_ledr_fader
// Purpose  : Per-channel linear PWM fader that drives the LEDR pins from the
//            PIO LED word, with an optional snap mode.
// Revision : 1.0 - initial release
// ============================================================================
module aula_20201105_ledr_fader #(
    parameter int N_LEDS   = 8,
    parameter int PWM_BITS = 8,
    parameter int FADE_DIV = 195
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic [N_LEDS-1:0] led_in,
    input  logic              fade_en,
    output logic [N_LEDS-1:0] ledr,
    output logic              busy
);

    localparam int                PRE_W    = (FADE_DIV > 1) ? $clog2(FADE_DIV) : 1;
    localparam logic [PRE_W-1:0]  PRE_LAST = PRE_W'(FADE_DIV - 1);
    localparam logic [PRE_W-1:0]  PRE_ONE  = PRE_W'(1);
    localparam logic [PWM_BITS-1:0] MAX    = '1;
    localparam logic [PWM_BITS-1:0] ONE    = PWM_BITS'(1);

    logic [N_LEDS-1:0]                led_q;
    logic [PWM_BITS-1:0]              pwm_cnt;
    logic [PRE_W-1:0]                 prescaler;
    logic                             tick;
    logic [N_LEDS-1:0][PWM_BITS-1:0]  level;
    logic [N_LEDS-1:0][PWM_BITS-1:0]  level_nxt;
    logic [N_LEDS-1:0]                off_target;

    assign tick = (prescaler == PRE_LAST);

    always_comb begin
        level_nxt  = level;
        off_target = '0;
        for (int i = 0; i < N_LEDS; i++) begin
            if (!fade_en) begin
                level_nxt[i] = led_q[i] ? MAX : '0;
            end else if (tick && led_q[i] && (level[i] != MAX)) begin
                level_nxt[i] = level[i] + ONE;
            end else if (tick && !led_q[i] && (level[i] != '0)) begin
                level_nxt[i] = level[i] - ONE;
            end
            // busy tracks the level being loaded this edge, so snap mode never flags busy
            off_target[i] = (level_nxt[i] != (led_q[i] ? MAX : '0));
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            led_q     <= '0;
            pwm_cnt   <= '0;
            prescaler <= '0;
            level     <= '0;
            ledr      <= '0;
            busy      <= 1'b0;
        end else begin
            led_q     <= led_in;
            pwm_cnt   <= pwm_cnt + ONE;
            prescaler <= tick ? '0 : prescaler + PRE_ONE;
            level     <= level_nxt;
            busy      <= |off_target;
            // full-scale forced high so MAX never shows a one-cycle dropout
            for (int i = 0; i < N_LEDS; i++) begin
                ledr[i] <= (level[i] == MAX) || (level[i] > pwm_cnt);
            end
        end
    end

endmodule
`default_nettype wire
